// File: rtl/tagged_stream_demux.sv
// Tag-routed demultiplexer: one {tag, payload} word per cycle is steered into one of
// FLUX independent first-word-fall-through FIFOs, each with its own full/empty/count.
module tagged_stream_demux #(
  parameter int DATA_W = 8,
  parameter int FLUX   = 4,
  parameter int DEPTH  = 16,
  parameter int TAG_W  = $clog2(FLUX),
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write,
  input  logic [DATA_W+TAG_W-1:0]  din,
  output logic [FLUX-1:0]          full,
  output logic [FLUX*DATA_W-1:0]   dout,
  output logic [FLUX-1:0]          empty,
  input  logic [FLUX-1:0]          read,
  output logic [FLUX*CNT_W-1:0]    count,
  output logic [FLUX-1:0]          overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [TAG_W-1:0]  tag_s;
  logic [DATA_W-1:0] payload_s;

  assign tag_s     = din[DATA_W+TAG_W-1:DATA_W];
  assign payload_s = din[DATA_W-1:0];

  for (genvar f = 0; f < FLUX; f++) begin : g_flow
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wp_r;
    logic [PTR_W-1:0]  rp_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              ovf_r;
    logic              hit_s;
    logic              full_s;
    logic              empty_s;
    logic              wr_en_s;
    logic              rd_en_s;
    logic              drop_s;

    // Full is judged on registered occupancy, so a read in the same cycle cannot rescue a write.
    always_comb begin
      hit_s   = write && (tag_s == TAG_W'(f));
      full_s  = (cnt_r == CNT_W'(DEPTH));
      empty_s = (cnt_r == {CNT_W{1'b0}});
      wr_en_s = hit_s && !full_s;
      drop_s  = hit_s && full_s;
      rd_en_s = read[f] && !empty_s;
    end

    // Pointer, occupancy and sticky overflow state for this flow.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wp_r  <= {PTR_W{1'b0}};
        rp_r  <= {PTR_W{1'b0}};
        cnt_r <= {CNT_W{1'b0}};
        ovf_r <= 1'b0;
      end else begin
        if (wr_en_s) begin
          wp_r <= wp_r + PTR_W'(1);
        end
        if (rd_en_s) begin
          rp_r <= rp_r + PTR_W'(1);
        end
        case ({wr_en_s, rd_en_s})
          2'b10:   cnt_r <= cnt_r + CNT_W'(1);
          2'b01:   cnt_r <= cnt_r - CNT_W'(1);
          default: cnt_r <= cnt_r;
        endcase
        if (drop_s) begin
          ovf_r <= 1'b1;
        end
      end
    end

    // Storage array is never reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
      if (wr_en_s && !rst) begin
        mem_r[wp_r] <= payload_s;
      end
    end

    assign full[f]                     = full_s;
    assign empty[f]                    = empty_s;
    assign overflow[f]                 = ovf_r;
    assign count[f*CNT_W +: CNT_W]     = cnt_r;
    assign dout[f*DATA_W +: DATA_W]    = mem_r[rp_r];
  end

endmodule

// File: tb/tb_tagged_stream_demux.sv
// Randomised scoreboard bench for tagged_stream_demux: per-flow expected queues are
// filled at stimulus time and drained by an independent negedge monitor.
module tb_tagged_stream_demux;

  localparam int DATA_W = 8;
  localparam int FLUX   = 4;
  localparam int DEPTH  = 16;
  localparam int TAG_W  = 2;
  localparam int CNT_W  = 5;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    write = 1'b0;
  logic [DATA_W+TAG_W-1:0] din = '0;
  logic [FLUX-1:0]         read = '0;
  logic [FLUX-1:0]         full;
  logic [FLUX*DATA_W-1:0]  dout;
  logic [FLUX-1:0]         empty;
  logic [FLUX*CNT_W-1:0]   count;
  logic [FLUX-1:0]         overflow;

  tagged_stream_demux #(.DATA_W(DATA_W), .FLUX(FLUX), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .write(write), .din(din), .full(full), .dout(dout),
    .empty(empty), .read(read), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: the words each flow must still deliver, oldest first.
  logic [DATA_W-1:0] exp_q [FLUX][$];
  int                pend_flow = -1;
  logic [FLUX-1:0]   exp_ovf  = '0;
  logic [FLUX-1:0]   pend_ovf = '0;
  int                checks = 0;
  int                errors = 0;

  task automatic chk(input string name, input int flow, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s flow %0d: got %0h, expected %0h at %0t", name, flow, act, exp, $time);
    end
  endtask

  // Monitor: compare status against model occupancy and pop a word for each effective read.
  always @(negedge clk) begin
    if (!rst) begin
      for (int f = 0; f < FLUX; f++) begin
        int mc;
        logic [DATA_W-1:0] e;
        mc = exp_q[f].size() - ((pend_flow == f) ? 1 : 0);
        chk("count", f, 32'(count[f*CNT_W +: CNT_W]), 32'(mc));
        chk("empty", f, 32'(empty[f]), 32'(mc == 0));
        chk("full", f, 32'(full[f]), 32'(mc == DEPTH));
        if (read[f] && mc > 0) begin
          e = exp_q[f].pop_front();
          chk("dout", f, 32'(dout[f*DATA_W +: DATA_W]), 32'(e));
        end
      end
      chk("overflow", -1, 32'(overflow), 32'(exp_ovf));
    end
  end

  task automatic step(input logic w, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d,
                      input logic [FLUX-1:0] r);
    @(posedge clk);
    #1;
    exp_ovf   = exp_ovf | pend_ovf;
    pend_ovf  = '0;
    pend_flow = -1;
    rst   = 1'b0;
    write = w;
    din   = {t, d};
    read  = r;
    if (w) begin
      if (exp_q[t].size() < DEPTH) begin
        exp_q[t].push_back(d);
        pend_flow = int'(t);
      end else begin
        pend_ovf[t] = 1'b1;
      end
    end
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      rst   = 1'b1;
      write = 1'b1;
      din   = (DATA_W+TAG_W)'($urandom);
      read  = FLUX'($urandom);
      for (int f = 0; f < FLUX; f++) exp_q[f].delete();
      pend_flow = -1;
      pend_ovf  = '0;
      exp_ovf   = '0;
    end
  endtask

  initial begin
    logic [FLUX-1:0] rm;

    do_reset(10);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    step(1'b0, 2'd0, 8'h00, 4'b0000);

    // Single flow fill and ordered drain
    for (int i = 0; i < 16; i++) step(1'b1, 2'd2, 8'(8'h10 + i), 4'b0000);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    for (int i = 0; i < 16; i++) step(1'b0, 2'd0, 8'h00, 4'b0100);
    step(1'b0, 2'd0, 8'h00, 4'b0000);

    // Round-robin fill of all flows, then parallel drain
    for (int i = 0; i < 64; i++) step(1'b1, 2'(i), 8'(8'hA0 + i), 4'b0000);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    for (int i = 0; i < 16; i++) step(1'b0, 2'd0, 8'h00, 4'b1111);
    step(1'b0, 2'd0, 8'h00, 4'b0000);

    // Overflow on flow 1, sticky through drain, cleared only by reset
    for (int i = 0; i < 16; i++) step(1'b1, 2'd1, 8'($urandom), 4'b0000);
    step(1'b1, 2'd1, 8'hEE, 4'b0000);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    for (int i = 0; i < 16; i++) step(1'b0, 2'd0, 8'h00, 4'b0010);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 8'h00, 4'b0000);
    do_reset(1);
    step(1'b0, 2'd0, 8'h00, 4'b0000);

    // Steady write+read on flow 3 at occupancy 5, crossing pointer wrap
    for (int i = 0; i < 5; i++) step(1'b1, 2'd3, 8'($urandom), 4'b0000);
    for (int i = 0; i < 40; i++) step(1'b1, 2'd3, 8'($urandom), 4'b1000);
    for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 8'h00, 4'b1000);

    // Underflow read, then reset discarding buffered words
    step(1'b0, 2'd0, 8'h00, 4'b0001);
    step(1'b0, 2'd0, 8'h00, 4'b0001);
    for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 8'($urandom), 4'b0000);
    do_reset(1);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    step(1'b0, 2'd0, 8'h00, 4'b0000);

    // Random traffic with alternating sparse/dense read phases
    for (int i = 0; i < 1500; i++) begin
      rm = (i % 300 < 150) ? FLUX'($urandom & $urandom & $urandom) : FLUX'($urandom);
      step(1'($urandom % 4 != 0), 2'($urandom), 8'($urandom), rm);
    end
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 2'd0, 8'h00, 4'b1111);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
